// File: rtl/mult_shift_seq_arb.sv
// Round-robin arbiter + sequencer sharing one shift-add multiplier among NREQ requesters.
// Define MULT_SHIFT_ZERO_SKIP_EN to end accumulation early once the remaining multiplier bits are zero.
module mult_shift_seq_arb #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2,
   parameter int ID_W  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*WIDTH-1:0]    rsp_prod,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy,
   output logic [1:0]            dbg_state
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    acc_d;
   logic [PW-1:0]    pp;
   logic [CNT_W-1:0] cnt_q;
   logic [ID_W-1:0]  id_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  ptr_d;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_valid;
   logic             rsp_valid_q;
   logic             last_bit;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // senders hold valid and payload stable until that edge, and ready never depends on it in ACC/DONE.
   always_comb begin : arbiter
      int j;
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!grant_valid && req_valid[j]) begin
            grant_valid = 1'b1;
            grant_idx   = ID_W'(j);
         end
      end
   end

   assign ptr_d     = ID_W'((int'(grant_idx) + 1) % NREQ);
   assign req_ready = (state_q == S_IDLE && grant_valid) ? (NREQ'(1) << grant_idx) : '0;

   assign pp    = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[cnt_q]}}} << cnt_q;
   assign acc_d = acc_q + pp;

`ifdef MULT_SHIFT_ZERO_SKIP_EN
   logic [WIDTH-1:0] b_rem;
   assign b_rem    = b_q >> cnt_q;
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1)) || ((b_rem >> 1) == '0);
`else
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         id_q        <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  a_q     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                  b_q     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  id_q    <= grant_idx;
                  ptr_q   <= ptr_d;
                  state_q <= S_ACC;
               end
            end
            S_ACC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_bit) state_q <= S_DONE;
            end
            S_DONE: begin
               // rsp_valid rises on the first DONE cycle, giving WIDTH+1 cycles from acceptance.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_prod  = acc_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;
endmodule

// File: tb/tb_mult_shift_seq_arb.sv
// Randomized bench for mult_shift_seq_arb: requests checked against a plain-arithmetic model
// (product a*b, round-robin grant order, latency from the multiplier bits).
module tb_mult_shift_seq_arb;
   localparam int WIDTH = 4;
   localparam int NREQ  = 2;
   localparam int ID_W  = 1;
   localparam int PW    = 2 * WIDTH;
   localparam int EW    = ID_W + PW;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [PW-1:0]         rsp_prod;
   logic [ID_W-1:0]       rsp_id;
   logic                  busy;
   logic [1:0]            dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_ptr = 0;

   logic [EW-1:0] exp_q[$];
   int            lat_q[$];
   int            edge_q[$];

   mult_shift_seq_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_prod  (rsp_prod),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] rnd();
      return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
   endfunction

   // Response latency counted from the acceptance edge.
   function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MULT_SHIFT_ZERO_SKIP_EN
      int hb;
      hb = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) hb = i;
      return hb + 2;
`else
      return WIDTH + 1 + 0 * int'(b);
`endif
   endfunction

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // driver tasks
   task automatic set_req(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[r*WIDTH +: WIDTH] = a;
      req_b[r*WIDTH +: WIDTH] = b;
      req_valid[r]            = 1'b1;
   endtask

   task automatic accept(input bit hold, output int g);
      bit ok;
      int mg;
      logic [WIDTH-1:0] av, bv;
      logic [PW-1:0] p;
      ok = 1'b0;
      g  = -1;
      mg = model_grant();
      for (int t = 0; t < 40 && !ok; t++) begin
         #1;
         total++;
         if ($countones(req_ready) > 1) begin
            bad++;
            $display("FAIL req_ready_onehot: got %b required at most one bit", req_ready);
         end
         if (req_ready != '0) begin
            ok = 1'b1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
         end else begin
            @(negedge clk);
         end
      end
      total++;
      if (!ok || g != mg) begin
         bad++;
         $display("FAIL grant: got %0d required %0d", g, mg);
      end
      if (ok && g >= 0) begin
         av = req_a[g*WIDTH +: WIDTH];
         bv = req_b[g*WIDTH +: WIDTH];
         p  = {{WIDTH{1'b0}}, av} * {{WIDTH{1'b0}}, bv};
         exp_q.push_back({ID_W'(g), p});
         lat_q.push_back(exp_lat(bv));
         edge_q.push_back(cyc + 1);
         m_ptr = (g + 1) % NREQ;
         @(negedge clk);
         req_a[g*WIDTH +: WIDTH] = rnd();
         req_b[g*WIDTH +: WIDTH] = rnd();
         if (!hold) req_valid[g] = 1'b0;
      end
   endtask

   // scoreboard: wait for the oldest expected response, apply bp cycles of backpressure
   task automatic collect(input int bp);
      logic [EW-1:0]   e;
      logic [PW-1:0]   hp;
      logic [ID_W-1:0] hi;
      int el, ea, lat, t;
      if (exp_q.size() == 0) return;
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      ea = edge_q.pop_front();
      t  = 0;
      #1;
      while (rsp_valid !== 1'b1 && t < 60) begin
         total++;
         if (busy !== 1'b1 || req_ready !== '0) begin
            bad++;
            $display("FAIL busy_wait: got busy=%b req_ready=%b required busy=1 req_ready=0", busy, req_ready);
         end
         @(negedge clk);
         #1;
         t++;
      end
      total++;
      if (rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL rsp_timeout: got rsp_valid=%b required 1", rsp_valid);
         return;
      end
      lat = cyc - ea;
      total++;
      if (lat != el) begin
         bad++;
         $display("FAIL latency: got %0d required %0d", lat, el);
      end
      total++;
      if (rsp_prod !== e[PW-1:0]) begin
         bad++;
         $display("FAIL rsp_prod: got %0d required %0d", rsp_prod, e[PW-1:0]);
      end
      total++;
      if (rsp_id !== e[EW-1:PW]) begin
         bad++;
         $display("FAIL rsp_id: got %0d required %0d", rsp_id, e[EW-1:PW]);
      end
      hp = rsp_prod;
      hi = rsp_id;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_prod !== hp || rsp_id !== hi || req_ready !== '0) begin
            bad++;
            $display("FAIL rsp_hold: got v=%b p=%0d id=%0d rdy=%b required v=1 p=%0d id=%0d rdy=0",
                     rsp_valid, rsp_prod, rsp_id, req_ready, hp, hi);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rsp_release: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      exp_q.delete();
      lat_q.delete();
      edge_q.delete();
      m_ptr = 0;
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_prod !== '0 || rsp_id !== '0 ||
          busy !== 1'b0 || dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b v=%b p=%0d id=%0d busy=%b st=%0d required all 0",
                  req_ready, rsp_valid, rsp_prod, rsp_id, busy, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int g;
      set_req(0, 4'd3, 4'd5);
      accept(1'b0, g);
      collect(0);
   endtask

   task automatic test_max();
      int g;
      set_req(1, 4'd15, 4'd15);
      accept(1'b0, g);
      collect(0);
      set_req(1, 4'd0, 4'd9);
      accept(1'b0, g);
      collect(0);
   endtask

   task automatic test_arbitration();
      int g;
      test_reset();
      set_req(0, rnd(), rnd());
      set_req(1, rnd(), rnd());
      for (int i = 0; i < 4; i++) begin
         accept(1'b1, g);
         total++;
         if (g != i % 2) begin
            bad++;
            $display("FAIL arb_order: op %0d got grant %0d required %0d", i, g, i % 2);
         end
         if (i == 3) req_valid = '0;
         collect(0);
      end
   endtask

   task automatic test_backpressure();
      int g;
      set_req(0, rnd(), rnd());
      accept(1'b0, g);
      set_req(1, rnd(), rnd());
      @(negedge clk);
      req_valid[1] = 1'b0;
      collect(3);
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL dropped_req: got busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int g;
      set_req(0, rnd(), rnd());
      accept(1'b0, g);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_prod !== '0 || rsp_id !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got rdy=%b v=%b p=%0d id=%0d busy=%b required all 0",
                  req_ready, rsp_valid, rsp_prod, rsp_id, busy);
      end
      exp_q.delete();
      lat_q.delete();
      edge_q.delete();
      m_ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         total++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL lost_op: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
         end
      end
      set_req(0, 4'd7, 4'd6);
      set_req(1, rnd(), rnd());
      accept(1'b0, g);
      req_valid = '0;
      total++;
      if (g != 0) begin
         bad++;
         $display("FAIL ptr_after_reset: got grant %0d required 0", g);
      end
      collect(0);
   endtask

   task automatic test_zero_skip();
      int g;
      logic [WIDTH-1:0] bs[3];
      bs[0] = 4'd1;
      bs[1] = 4'd8;
      bs[2] = 4'd0;
      for (int i = 0; i < 3; i++) begin
         set_req(0, rnd(), bs[i]);
         accept(1'b0, g);
         collect(0);
      end
   endtask

   task automatic test_random();
      int g;
      for (int i = 0; i < 12; i++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (!req_valid[r] && $urandom_range(0, 1) == 1) set_req(r, rnd(), rnd());
         end
         if (req_valid == '0) set_req($urandom_range(0, NREQ - 1), rnd(), rnd());
         accept(1'b0, g);
         collect($urandom_range(0, 2));
      end
      for (int k = 0; k < NREQ && req_valid != '0; k++) begin
         accept(1'b0, g);
         collect(0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      test_zero_skip();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
